// File: rtl/wb_regfile_if.sv
// wb_regfile_if
//   Bus bundle between the MEM/WB pipe register / decode stage and the
//   write-back register file.
//   slave  modport : used by wb_regfile (write-back inputs, read requests in;
//                    read data, forwarding value, write strobe, counter out)
//   master modport : used by the driving side (pipeline or testbench)
//
//   Signals:
//     wb_valid, wb_reg_write, wb_mem_to_reg  write-back control
//     data_in_a (memory), data_in_b (ALU)    write-back data candidates
//     rd_in                                  destination register index
//     rd_en_a/rs_a, rd_en_b/rs_b             read-port enables and addresses
//     rdata_a, rdata_b                       registered read data
//     wb_data, wb_we                         combinational forwarding value/strobe
//     wr_count                               committed register write counter
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [DATA_W-1:0] data_in_a;
    logic [DATA_W-1:0] data_in_b;
    logic [ADDR_W-1:0] rd_in;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rs_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rs_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic [CNT_W-1:0]  wr_count;

    modport slave (
        input  wb_valid, wb_reg_write, wb_mem_to_reg,
        input  data_in_a, data_in_b, rd_in,
        input  rd_en_a, rs_a, rd_en_b, rs_b,
        output rdata_a, rdata_b, wb_data, wb_we, wr_count
    );

    modport master (
        output wb_valid, wb_reg_write, wb_mem_to_reg,
        output data_in_a, data_in_b, rd_in,
        output rd_en_a, rs_a, rd_en_b, rs_b,
        input  rdata_a, rdata_b, wb_data, wb_we, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
//   Write-back end of the MEM/WB stage. Selects the write-back value (memory
//   or ALU), commits it to a 2**ADDR_W x DATA_W integer register file, and
//   serves two registered read ports with write-to-read bypass. Register 0
//   always reads as zero. Counts committed writes (wraps silently).
//
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-low reset; clears registers, read data
//              and the write counter
//     bus      wb_regfile_if.slave (write-back inputs, read ports, wb_data,
//              wb_we, wr_count)
//
//   Optional: define WB_REGFILE_DEBUG_EN to add
//     dbg_addr (in)  / dbg_data (out): combinational, unbypassed peek at
//     regs[dbg_addr]; index 0 returns 0.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    wb_regfile_if.slave       bus
`ifdef WB_REGFILE_DEBUG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    logic [DATA_W-1:0] wb_data;
    logic              wb_we;

    // Valid gates everything, so X on rd_in/data in an empty slot never
    // reaches the array or the counter.
    assign wb_data = bus.wb_mem_to_reg ? bus.data_in_a : bus.data_in_b;
    assign wb_we   = bus.wb_valid & bus.wb_reg_write & (bus.rd_in != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[bus.rd_in] = wb_data;
        end
    end

    // Read ports: x0 forced to zero, same-cycle write bypassed to the reader.
    always_comb begin
        rdata_a_d = rdata_a_q;
        if (bus.rd_en_a) begin
            if (bus.rs_a == '0) begin
                rdata_a_d = '0;
            end else if (wb_we && (bus.rs_a == bus.rd_in)) begin
                rdata_a_d = wb_data;
            end else begin
                rdata_a_d = regs_q[bus.rs_a];
            end
        end
    end

    always_comb begin
        rdata_b_d = rdata_b_q;
        if (bus.rd_en_b) begin
            if (bus.rs_b == '0) begin
                rdata_b_d = '0;
            end else if (wb_we && (bus.rs_b == bus.rd_in)) begin
                rdata_b_d = wb_data;
            end else begin
                rdata_b_d = regs_q[bus.rs_b];
            end
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wb_we) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.wb_data  = wb_data;
    assign bus.wb_we    = wb_we;
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.wr_count = wr_count_q;

`ifdef WB_REGFILE_DEBUG_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back end of the MEM/WB pipe register: consumes the MEM/WB outputs (memory data, ALU data, destination register), selects the write-back value and commits it to a 32 x 32-bit integer register file. Provides two synchronous read ports for the decode stage with write-to-read bypass. Register 0 reads as zero and ignores writes. Also keeps a retired-write counter for debug and performance.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register index width; depth = 2**ADDR_W
CNT_W, 32, width of retired-write counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
wb_valid  in  1  MEM/WB slot holds a valid instruction
wb_reg_write  in  1  instruction writes a register
wb_mem_to_reg  in  1  1 = write data_in_a (memory), 0 = write data_in_b (ALU)
data_in_a  in  DATA_W  memory read data from MEM/WB
data_in_b  in  DATA_W  ALU result from MEM/WB
rd_in  in  ADDR_W  destination register from MEM/WB
rd_en_a  in  1  read-port A enable
rs_a  in  ADDR_W  read-port A address
rd_en_b  in  1  read-port B enable
rs_b  in  ADDR_W  read-port B address
rdata_a  out  DATA_W  read-port A data, registered
rdata_b  out  DATA_W  read-port B data, registered
wb_data  out  DATA_W  selected write-back value, combinational, for EX forwarding
wb_we  out  1  effective write strobe, combinational
wr_count  out  CNT_W  number of committed register writes

Behaviour:
- wb_data = wb_mem_to_reg ? data_in_a : data_in_b. Computed regardless of valid.
- wb_we = wb_valid & wb_reg_write & (rd_in != 0).
- Write: on a rising clk with wb_we=1, regs[rd_in] <= wb_data. Writes to index 0 are discarded. regs[0] is always 0.
- Read latency is 1 cycle. On a rising clk with rd_en_x=1, rdata_x <= value of regs[rs_x] for that cycle. With rd_en_x=0, rdata_x holds its value.
- Bypass: if rd_en_x=1, wb_we=1 and rs_x==rd_in in the same cycle, rdata_x <= wb_data, the new value, not the stale entry.
- Read of rs_x==0 always returns 0, including when a write to 0 is attempted in the same cycle.
- Ports A and B are independent. Both may read the same address, and both may bypass in the same cycle.
- wr_count increments by 1 on each clk edge with wb_we=1. Wraps from all-ones to 0 with no flag.
- Async reset (rst=0): all regs, rdata_a, rdata_b and wr_count go to 0 immediately, with no clock required. They stay 0 while rst=0, and writes and reads are ignored. Release is synchronous to the next rising clk; the first write can occur on the first edge with rst=1.
- Reset asserted mid-write: the write is lost and the entry reads 0.
- X on rd_in or data while wb_valid=0 must not corrupt state.

Optional Feature:
Macro WB_REGFILE_DEBUG_EN.
- Defined: adds ports dbg_addr (in, ADDR_W) and dbg_data (out, DATA_W). dbg_data = regs[dbg_addr], combinational, with no bypass (shows the pre-write value in the cycle of a write). dbg_addr=0 returns 0.
- Undefined: the ports do not exist, and no extra logic or read mux is present.

Test Plan:
- Reset: drive rst=0 mid-cycle after prior writes -> rdata_a, rdata_b and wr_count go to 0 immediately. Reading any register after release returns 0.
- Write then read: write x5=0xDEADBEEF with wb_mem_to_reg=0 (data_in_b), then next cycle read rs_a=5 -> rdata_a=0xDEADBEEF one cycle later, and wr_count=1.
- Select and bypass: in the same cycle, write x7 with mem_to_reg=1, data_in_a=0x1234, and read rs_a=7, rs_b=7 -> both rdata=0x1234 on the next edge.
- Zero register: write rd_in=0, data 0xFFFFFFFF, valid=1 -> wb_we=0, a read of x0 returns 0 (also in the same cycle), and wr_count is unchanged.
- Gating: wb_valid=0 with reg_write=1, rd=3, data 0xAA, then read x3 -> 0. Set rd_en_a=0 while x3 changes -> rdata_a holds its previous value.
- Counter wrap (CNT_W=4): 17 valid writes -> wr_count=1.
